// File: rtl/ysyx_25060170_alu_issue_if.sv
// Handshake bundle between register read, the ALU issue buffer and the execute stage.
// The slave modport is the issue block; the master modport is its surrounding pipeline.
interface ysyx_25060170_alu_issue_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] inst;
  logic [31:0] pc;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  alu_op;
  logic [31:0] sr1;
  logic [31:0] sr2;
  logic        br_inv;
  logic        illegal;

  modport master (
    output in_valid, inst, pc, rs1_val, rs2_val, out_ready,
    input  in_ready, out_valid, alu_op, sr1, sr2, br_inv, illegal
  );

  modport slave (
    input  in_valid, inst, pc, rs1_val, rs2_val, out_ready,
    output in_ready, out_valid, alu_op, sr1, sr2, br_inv, illegal
  );
endinterface

// File: rtl/ysyx_25060170_alu_issue.sv
// Decodes one RV32I instruction per handshake into ALU opcode/operands and
// holds the results in a registered 2-entry FIFO feeding the ALU inputs.
module ysyx_25060170_alu_issue (
  input logic                      clk,
  input logic                      rst_n,
  ysyx_25060170_alu_issue_if.slave bus
);
  typedef struct packed {
    logic [3:0]  alu_op;
    logic [31:0] sr1;
    logic [31:0] sr2;
    logic        br_inv;
    logic        illegal;
  } entry_t;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_OR  = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_EQ  = 4'd4;
  localparam logic [3:0] OP_LTU = 4'd5;

  function automatic logic signed [31:0] sext12(input logic [11:0] v);
    return $signed({{20{v[11]}}, v});
  endfunction

  function automatic entry_t mk(input logic [3:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic inv);
    entry_t e;
    e.alu_op  = op;
    e.sr1     = a;
    e.sr2     = b;
    e.br_inv  = inv;
    e.illegal = 1'b0;
    return e;
  endfunction

  // Stage p0: combinational decode of the incoming bundle
  logic [6:0]         opc_p0;
  logic [2:0]         f3_p0;
  logic [6:0]         f7_p0;
  logic signed [31:0] imm_i_p0, imm_s_p0, imm_u_p0;
  logic [31:0]        a_p0, b_p0, ui_p0, us_p0, uu_p0;
  entry_t             ent_p0;
  entry_t             ill_p0;
  logic               vld_p0;

  assign opc_p0   = bus.inst[6:0];
  assign f3_p0    = bus.inst[14:12];
  assign f7_p0    = bus.inst[31:25];
  assign imm_i_p0 = sext12(bus.inst[31:20]);
  assign imm_s_p0 = sext12({bus.inst[31:25], bus.inst[11:7]});
  assign imm_u_p0 = $signed({bus.inst[31:12], 12'b0});
  assign a_p0     = bus.rs1_val;
  assign b_p0     = bus.rs2_val;
  assign ui_p0    = $unsigned(imm_i_p0);
  assign us_p0    = $unsigned(imm_s_p0);
  assign uu_p0    = $unsigned(imm_u_p0);
  assign ill_p0   = '{alu_op: 4'd0, sr1: 32'd0, sr2: 32'd0, br_inv: 1'b0, illegal: 1'b1};

  always_comb begin
    ent_p0 = ill_p0;
    case (opc_p0)
      7'b0110011: begin
        if (f7_p0 == 7'b0000000) begin
          case (f3_p0)
            3'b000:  ent_p0 = mk(OP_ADD, a_p0, b_p0, 1'b0);
            3'b110:  ent_p0 = mk(OP_OR,  a_p0, b_p0, 1'b0);
            3'b111:  ent_p0 = mk(OP_AND, a_p0, b_p0, 1'b0);
            3'b011:  ent_p0 = mk(OP_LTU, a_p0, b_p0, 1'b0);
            default: ent_p0 = ill_p0;
          endcase
        end else if (f7_p0 == 7'b0100000 && f3_p0 == 3'b000) begin
          ent_p0 = mk(OP_SUB, a_p0, b_p0, 1'b0);
        end
      end
      7'b0010011: begin
        case (f3_p0)
          3'b000:  ent_p0 = mk(OP_ADD, a_p0, ui_p0, 1'b0);
          3'b110:  ent_p0 = mk(OP_OR,  a_p0, ui_p0, 1'b0);
          3'b111:  ent_p0 = mk(OP_AND, a_p0, ui_p0, 1'b0);
          3'b011:  ent_p0 = mk(OP_LTU, a_p0, ui_p0, 1'b0);
          default: ent_p0 = ill_p0;
        endcase
      end
      7'b0110111: ent_p0 = mk(OP_ADD, 32'd0,  uu_p0, 1'b0);
      7'b0010111: ent_p0 = mk(OP_ADD, bus.pc, uu_p0, 1'b0);
      7'b0000011: ent_p0 = mk(OP_ADD, a_p0,   ui_p0, 1'b0);
      7'b0100011: ent_p0 = mk(OP_ADD, a_p0,   us_p0, 1'b0);
      7'b1100011: begin
        case (f3_p0)
          3'b000:  ent_p0 = mk(OP_EQ,  a_p0, b_p0, 1'b0);
          3'b001:  ent_p0 = mk(OP_EQ,  a_p0, b_p0, 1'b1);
          3'b110:  ent_p0 = mk(OP_LTU, a_p0, b_p0, 1'b0);
          3'b111:  ent_p0 = mk(OP_LTU, a_p0, b_p0, 1'b1);
          default: ent_p0 = ill_p0;
        endcase
      end
      default: ent_p0 = ill_p0;
    endcase
  end

  // Stage p1: 2-entry buffer; outputs come only from registered storage
  entry_t     buf_p1 [2];
  logic       wptr_p1, rptr_p1;
  logic [1:0] cnt_p1;
  logic       vld_p1;
  logic       push, pop;

  assign vld_p0       = bus.in_valid;
  assign vld_p1       = (cnt_p1 != 2'd0);
  assign bus.in_ready = (cnt_p1 != 2'd2);
  assign push         = vld_p0 && bus.in_ready;
  assign pop          = vld_p1 && bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_p1[0] <= '0;
      buf_p1[1] <= '0;
      wptr_p1   <= 1'b0;
      rptr_p1   <= 1'b0;
      cnt_p1    <= 2'd0;
    end else begin
      if (push) begin
        buf_p1[wptr_p1] <= ent_p0;
        wptr_p1         <= ~wptr_p1;
      end
      if (pop) rptr_p1 <= ~rptr_p1;
      case ({push, pop})
        2'b10:   cnt_p1 <= cnt_p1 + 2'd1;
        2'b01:   cnt_p1 <= cnt_p1 - 2'd1;
        default: cnt_p1 <= cnt_p1;
      endcase
    end
  end

  assign bus.out_valid = vld_p1;
  assign bus.alu_op    = buf_p1[rptr_p1].alu_op;
  assign bus.sr1       = buf_p1[rptr_p1].sr1;
  assign bus.sr2       = buf_p1[rptr_p1].sr2;
  assign bus.br_inv    = buf_p1[rptr_p1].br_inv;
  assign bus.illegal   = buf_p1[rptr_p1].illegal;
endmodule

// File: tb/tb_ysyx_25060170_alu_issue.sv
// Directed bench for the ALU issue buffer: decode vectors, backpressure,
// streaming order and asynchronous reset.
module tb_ysyx_25060170_alu_issue;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  ysyx_25060170_alu_issue_if bus ();

  ysyx_25060170_alu_issue dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed head view: {alu_op, sr1, sr2, br_inv, illegal}
  function automatic logic [69:0] head();
    return {bus.alu_op, bus.sr1, bus.sr2, bus.br_inv, bus.illegal};
  endfunction

  task automatic push_one(input logic [31:0] i, input logic [31:0] p,
                          input logic [31:0] r1, input logic [31:0] r2);
    bus.inst     = i;
    bus.pc       = p;
    bus.rs1_val  = r1;
    bus.rs2_val  = r2;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic pop_one();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [69:0] h;
    rst_n = 1'b0;
    #2;
    h = head();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready);
    end
    checks++;
    if (h !== 70'd0) begin
      failures++; $display("FAIL reset_outputs got=%h exp=0", h);
    end
    @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  task automatic test_addi();
    logic [69:0] h;
    push_one(32'hFFF10093, 32'h0, 32'd5, 32'd0);
    h = head();
    checks++;
    if (bus.out_valid !== 1'b1) begin
      failures++; $display("FAIL addi_valid got=%b exp=1", bus.out_valid);
    end
    checks++;
    if (h !== {4'd0, 32'd5, 32'hFFFFFFFF, 1'b0, 1'b0}) begin
      failures++; $display("FAIL addi_entry got=%h exp=%h", h, {4'd0, 32'd5, 32'hFFFFFFFF, 1'b0, 1'b0});
    end
    pop_one();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++; $display("FAIL addi_drain got=%b exp=0", bus.out_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [69:0] h;
    bus.out_ready = 1'b0;
    push_one(32'h40208033, 32'h0, 32'd10, 32'd3);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++; $display("FAIL bp_ready_one got=%b exp=1", bus.in_ready);
    end
    push_one(32'h0020F463, 32'h0, 32'd1, 32'd2);
    checks++;
    if (bus.in_ready !== 1'b0) begin
      failures++; $display("FAIL bp_ready_full got=%b exp=0", bus.in_ready);
    end
    // A bundle offered while full must be ignored
    push_one(32'h123450B7, 32'h0, 32'd0, 32'd0);
    h = head();
    checks++;
    if (h !== {4'd1, 32'd10, 32'd3, 1'b0, 1'b0}) begin
      failures++; $display("FAIL bp_head_sub got=%h exp=%h", h, {4'd1, 32'd10, 32'd3, 1'b0, 1'b0});
    end
    pop_one();
    h = head();
    checks++;
    if (h !== {4'd5, 32'd1, 32'd2, 1'b1, 1'b0}) begin
      failures++; $display("FAIL bp_head_bgeu got=%h exp=%h", h, {4'd5, 32'd1, 32'd2, 1'b1, 1'b0});
    end
    checks++;
    if ({bus.out_valid, bus.in_ready} !== 2'b11) begin
      failures++; $display("FAIL bp_count_one got=%b exp=11", {bus.out_valid, bus.in_ready});
    end
    pop_one();
    checks++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      failures++; $display("FAIL bp_empty got=%b exp=01", {bus.out_valid, bus.in_ready});
    end
  endtask

  task automatic test_upper();
    logic [69:0] h;
    push_one(32'h123450B7, 32'h0, 32'hDEAD, 32'hBEEF);
    h = head();
    checks++;
    if (h !== {4'd0, 32'd0, 32'h12345000, 1'b0, 1'b0}) begin
      failures++; $display("FAIL lui got=%h exp=%h", h, {4'd0, 32'd0, 32'h12345000, 1'b0, 1'b0});
    end
    pop_one();
    push_one(32'h00001097, 32'h80000000, 32'hDEAD, 32'hBEEF);
    h = head();
    checks++;
    if (h !== {4'd0, 32'h80000000, 32'h00001000, 1'b0, 1'b0}) begin
      failures++; $display("FAIL auipc got=%h exp=%h", h, {4'd0, 32'h80000000, 32'h00001000, 1'b0, 1'b0});
    end
    pop_one();
  endtask

  task automatic test_illegal();
    logic [69:0] h;
    push_one(32'h00000000, 32'h1234, 32'h55, 32'h66);
    h = head();
    checks++;
    if ({bus.out_valid, h} !== {1'b1, 69'd0, 1'b1}) begin
      failures++; $display("FAIL illegal_zero got=%h exp=%h", {bus.out_valid, h}, {1'b1, 69'd0, 1'b1});
    end
    pop_one();
    push_one(32'h4020E033, 32'h0, 32'h77, 32'h88);
    h = head();
    checks++;
    if ({bus.out_valid, h} !== {1'b1, 69'd0, 1'b1}) begin
      failures++; $display("FAIL illegal_or_f7 got=%h exp=%h", {bus.out_valid, h}, {1'b1, 69'd0, 1'b1});
    end
    pop_one();
  endtask

  logic [31:0] s_inst [8] = '{32'h002081B3, 32'h0020F1B3, 32'hFFF0B193, 32'h7FF0E193,
                              32'hFFC0A183, 32'hFE20AC23, 32'h00208463, 32'h00209463};
  logic [31:0] s_rs1  [8] = '{32'd7, 32'hF0F0, 32'd3, 32'd1, 32'h100, 32'h200, 32'd4, 32'd5};
  logic [31:0] s_rs2  [8] = '{32'd9, 32'hFF00, 32'd0, 32'd0, 32'd0, 32'hAA, 32'd4, 32'd6};
  logic [69:0] s_exp  [8] = '{
    {4'd0, 32'd7,     32'd9,          1'b0, 1'b0},
    {4'd3, 32'hF0F0,  32'hFF00,       1'b0, 1'b0},
    {4'd5, 32'd3,     32'hFFFFFFFF,   1'b0, 1'b0},
    {4'd2, 32'd1,     32'h000007FF,   1'b0, 1'b0},
    {4'd0, 32'h100,   32'hFFFFFFFC,   1'b0, 1'b0},
    {4'd0, 32'h200,   32'hFFFFFFF8,   1'b0, 1'b0},
    {4'd4, 32'd4,     32'd4,          1'b0, 1'b0},
    {4'd4, 32'd5,     32'd6,          1'b1, 1'b0}};

  task automatic test_stream();
    logic [15:0] pat;
    logic [69:0] h;
    int wi;
    int ri;
    logic pp;
    logic pushed;
    logic popped;
    pat = 16'b0110_1110_0111_1011;
    wi = 0;
    ri = 0;
    pp = 1'b0;
    for (int cyc = 0; cyc < 80 && ri < 8; cyc++) begin
      bus.out_ready = pat[cyc % 16];
      bus.in_valid  = (wi < 8);
      if (wi < 8) begin
        bus.inst    = s_inst[wi];
        bus.pc      = 32'h0;
        bus.rs1_val = s_rs1[wi];
        bus.rs2_val = s_rs2[wi];
      end
      @(negedge clk);
      pushed = bus.in_valid && bus.in_ready;
      popped = bus.out_valid && bus.out_ready;
      if (pushed && popped) pp = 1'b1;
      if (popped) begin
        h = head();
        checks++;
        if (h !== s_exp[ri]) begin
          failures++; $display("FAIL stream_entry%0d got=%h exp=%h", ri, h, s_exp[ri]);
        end
        ri++;
      end
      if (pushed) wi++;
      @(posedge clk);
      #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    checks++;
    if (ri !== 8) begin
      failures++; $display("FAIL stream_count got=%0d exp=8", ri);
    end
    checks++;
    if (pp !== 1'b1) begin
      failures++; $display("FAIL stream_push_pop_same_cycle got=%b exp=1", pp);
    end
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++; $display("FAIL stream_no_dup got=%b exp=0", bus.out_valid);
    end
  endtask

  task automatic test_reset_mid();
    logic [69:0] h;
    bus.out_ready = 1'b0;
    push_one(32'h002081B3, 32'h0, 32'd1, 32'd2);
    push_one(32'h40208033, 32'h0, 32'd3, 32'd4);
    #3;
    rst_n = 1'b0;
    #1;
    h = head();
    checks++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      failures++; $display("FAIL rst_mid_flags got=%b exp=01", {bus.out_valid, bus.in_ready});
    end
    checks++;
    if (h !== 70'd0) begin
      failures++; $display("FAIL rst_mid_outputs got=%h exp=0", h);
    end
    #2;
    rst_n = 1'b1;
    push_one(32'h123450B7, 32'h0, 32'd0, 32'd0);
    h = head();
    checks++;
    if ({bus.out_valid, h} !== {1'b1, 4'd0, 32'd0, 32'h12345000, 1'b0, 1'b0}) begin
      failures++; $display("FAIL rst_first_push got=%h exp=%h", {bus.out_valid, h}, {1'b1, 4'd0, 32'd0, 32'h12345000, 1'b0, 1'b0});
    end
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.inst      = 32'h0;
    bus.pc        = 32'h0;
    bus.rs1_val   = 32'h0;
    bus.rs2_val   = 32'h0;
    test_reset();
    test_addi();
    test_backpressure();
    test_upper();
    test_illegal();
    test_stream();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
